// File: rtl/spi_slave_sync_pkg.sv
// Shared types and helpers for the system-clocked SPI slave.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } spi_state_e;

  localparam int unsigned SYNC_STAGES = 2;

  // Sample edge is rising when the idle level equals the phase bit (modes 0 and 3).
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return cpol == cpha;
  endfunction

endpackage

// File: rtl/spi_slave_sync_if.sv
// Word-side handshake between the SPI slave and the register/command logic.
interface spi_slave_sync_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_underrun;

  modport slave (
    output rx_data,
    output rx_valid,
    output tx_ready,
    output tx_underrun,
    input  tx_data,
    input  tx_valid
  );

  modport master (
    input  rx_data,
    input  rx_valid,
    input  tx_ready,
    input  tx_underrun,
    output tx_data,
    output tx_valid
  );

endinterface

// File: rtl/spi_slave_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with optional rise/fall pulses
// derived from one extra history flop.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0,
  parameter bit   EDGE_EN   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

  if (EDGE_EN) begin : g_edge
    logic last_q, last_d;

    always_comb begin
      last_d = q_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        last_q <= RESET_VAL;
      end else begin
        last_q <= last_d;
      end
    end

    assign rise_o = q_o & ~last_q;
    assign fall_o = ~q_o & last_q;
  end else begin : g_no_edge
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
  end

endmodule

// File: rtl/spi_slave_sync.sv
// Full-duplex SPI slave oversampled on the system clock, all CPOL/CPHA modes.
// Define SPI_SLAVE_FRAME_ERR_EN to enable the frame_err pulse on truncated words.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter bit                CPOL      = 1'b0,
  parameter bit                CPHA      = 1'b0,
  parameter bit                MSB_FIRST = 1'b1,
  parameter logic [DATA_W-1:0] TX_IDLE   = '1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            SCK,
  input  logic            MOSI,
  input  logic            SS,
  output logic            MISO,
  output logic            miso_oe,
  output logic            busy,
  output logic            frame_err,
  spi_slave_sync_if.slave bus
);

  localparam int unsigned     CntW       = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] CntFull    = CntW'(DATA_W);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  localparam bit              SampleRise = sample_on_rise(CPOL, CPHA);

  logic sck_s, sck_rise, sck_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_sync_edge #(
    .RESET_VAL (CPOL),
    .EDGE_EN   (1'b1)
  ) u_sck_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (SCK),
    .q_o    (sck_s),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_sync_edge #(
    .RESET_VAL (1'b1),
    .EDGE_EN   (1'b1)
  ) u_ss_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (SS),
    .q_o    (ss_s),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_sync_edge #(
    .RESET_VAL (1'b0),
    .EDGE_EN   (1'b0)
  ) u_mosi_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (MOSI),
    .q_o    (mosi_s),
    .rise_o (mosi_rise),
    .fall_o (mosi_fall)
  );

  // SS is handled by level so a missed rise pulse can never strand the FSM.
  assign unused_sync = ^{sck_s, ss_rise, mosi_rise, mosi_fall};

  logic sample_edge, shift_edge;
  assign sample_edge = SampleRise ? sck_rise : sck_fall;
  assign shift_edge  = SampleRise ? sck_fall : sck_rise;

  spi_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic              underrun_q, underrun_d;
  logic              tx_accept;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic              frame_err_q, frame_err_d;
`endif

  assign tx_accept = bus.tx_valid && !buf_full_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    underrun_d = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    frame_err_d = 1'b0;
`endif

    if (tx_accept) begin
      buf_d      = bus.tx_data;
      buf_full_d = 1'b1;
    end

    if (ss_s && (state_q != IDLE)) begin
      // A word whose last bit landed just before SS rose is still delivered.
      if ((state_q == SHIFT) && (cnt_q == CntFull)) begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_d = (state_q == SHIFT) && (cnt_q != '0) && (cnt_q < CntFull);
`endif
      state_d    = IDLE;
      cnt_d      = '0;
      rx_shift_d = '0;
      tx_shift_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_d = LOAD;
          end
        end
        LOAD: begin
          if (buf_full_q) begin
            tx_shift_d = buf_q;
            buf_full_d = 1'b0;
          end else begin
            tx_shift_d = TX_IDLE;
            underrun_d = 1'b1;
          end
          cnt_d   = '0;
          state_d = SHIFT;
        end
        SHIFT: begin
          if (cnt_q == CntFull) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            cnt_d      = '0;
            state_d    = LOAD;
          end else begin
            if (sample_edge) begin
              rx_shift_d = MSB_FIRST ? {rx_shift_q[DATA_W-2:0], mosi_s}
                                     : {mosi_s, rx_shift_q[DATA_W-1:1]};
              cnt_d      = cnt_q + CntOne;
            end
            // With cnt at zero the shift edge either precedes the first sample
            // (CPHA=1) or trails the previous word's last bit (CPHA=0).
            if (shift_edge && (cnt_q != '0)) begin
              tx_shift_d = MSB_FIRST ? {tx_shift_q[DATA_W-2:0], 1'b0}
                                     : {1'b0, tx_shift_q[DATA_W-1:1]};
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      underrun_q <= underrun_d;
    end
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  assign MISO            = MSB_FIRST ? tx_shift_q[DATA_W-1] : tx_shift_q[0];
  assign miso_oe         = ~ss_s;
  assign busy            = ~ss_s;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_ready    = ~buf_full_q;
  assign bus.tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Scoreboard bench: four slaves (modes 0..3) share SCK/MOSI, each with its own SS.
module tb_spi_slave_sync;

  localparam int HALF = 50;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  localparam int FerrExp = 1;
`else
  localparam int FerrExp = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       sck;
  logic       mosi;
  logic [3:0] ss;
  logic [3:0] miso, miso_oe, busy, frame_err;

  logic [31:0] tx_data_v  [4];
  logic        tx_valid_v [4];
  logic [31:0] rx_data_v  [4];
  logic        rx_valid_v [4];
  logic        tx_ready_v [4];
  logic        und_v      [4];

  typedef struct {
    int          inst;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks, failures;
  int   rxv_cnt [4];
  int   und_cnt [4];
  int   und_at_rxv [4];
  int   ferr_cnt;
  logic [31:0] m1, m2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_slave_sync_if #(.DATA_W(8))  bus0 ();
  spi_slave_sync_if #(.DATA_W(8))  bus1 ();
  spi_slave_sync_if #(.DATA_W(16)) bus2 ();
  spi_slave_sync_if #(.DATA_W(8))  bus3 ();

  assign bus0.tx_data = tx_data_v[0][7:0];
  assign bus1.tx_data = tx_data_v[1][7:0];
  assign bus2.tx_data = tx_data_v[2][15:0];
  assign bus3.tx_data = tx_data_v[3][7:0];
  assign bus0.tx_valid = tx_valid_v[0];
  assign bus1.tx_valid = tx_valid_v[1];
  assign bus2.tx_valid = tx_valid_v[2];
  assign bus3.tx_valid = tx_valid_v[3];
  assign rx_data_v[0] = {24'h0, bus0.rx_data};
  assign rx_data_v[1] = {24'h0, bus1.rx_data};
  assign rx_data_v[2] = {16'h0, bus2.rx_data};
  assign rx_data_v[3] = {24'h0, bus3.rx_data};
  assign rx_valid_v[0] = bus0.rx_valid;
  assign rx_valid_v[1] = bus1.rx_valid;
  assign rx_valid_v[2] = bus2.rx_valid;
  assign rx_valid_v[3] = bus3.rx_valid;
  assign tx_ready_v[0] = bus0.tx_ready;
  assign tx_ready_v[1] = bus1.tx_ready;
  assign tx_ready_v[2] = bus2.tx_ready;
  assign tx_ready_v[3] = bus3.tx_ready;
  assign und_v[0] = bus0.tx_underrun;
  assign und_v[1] = bus1.tx_underrun;
  assign und_v[2] = bus2.tx_underrun;
  assign und_v[3] = bus3.tx_underrun;

  spi_slave_sync #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u_m0 (
    .clk(clk), .rst_n(rst_n), .SCK(sck), .MOSI(mosi), .SS(ss[0]), .MISO(miso[0]),
    .miso_oe(miso_oe[0]), .busy(busy[0]), .frame_err(frame_err[0]), .bus(bus0.slave));
  spi_slave_sync #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .SCK(sck), .MOSI(mosi), .SS(ss[1]), .MISO(miso[1]),
    .miso_oe(miso_oe[1]), .busy(busy[1]), .frame_err(frame_err[1]), .bus(bus1.slave));
  spi_slave_sync #(.DATA_W(16), .CPOL(1'b1), .CPHA(1'b0), .MSB_FIRST(1'b1)) u_m2 (
    .clk(clk), .rst_n(rst_n), .SCK(sck), .MOSI(mosi), .SS(ss[2]), .MISO(miso[2]),
    .miso_oe(miso_oe[2]), .busy(busy[2]), .frame_err(frame_err[2]), .bus(bus2.slave));
  spi_slave_sync #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) u_m3 (
    .clk(clk), .rst_n(rst_n), .SCK(sck), .MOSI(mosi), .SS(ss[3]), .MISO(miso[3]),
    .miso_oe(miso_oe[3]), .busy(busy[3]), .frame_err(frame_err[3]), .bus(bus3.slave));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic buf_write(input int sel, input logic [31:0] d);
    @(negedge clk);
    check("tx_ready_before_write", 32'(tx_ready_v[sel]), 32'd1);
    tx_data_v[sel]  = d;
    tx_valid_v[sel] = 1'b1;
    @(negedge clk);
    tx_valid_v[sel] = 1'b0;
    check("tx_ready_buffer_full", 32'(tx_ready_v[sel]), 32'd0);
  endtask

  task automatic ss_low(input int sel, input bit cpol);
    sck = cpol;
    #100;
    ss[sel] = 1'b0;
    #100;
  endtask

  task automatic ss_high(input int sel);
    #20;
    ss[sel] = 1'b1;
    #150;
  endtask

  // Master side: drives nbits of mosi_w and captures MISO on each sample edge.
  task automatic spi_frame(input int sel, input int width, input bit cpol, input bit cpha,
                           input bit msb, input logic [31:0] mosi_w, input int nbits,
                           output logic [31:0] miso_w);
    int idx;
    miso_w = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = msb ? (width - 1 - i) : i;
      if (!cpha) begin
        mosi = mosi_w[idx];
        #HALF;
        sck = ~cpol;
        miso_w[idx] = miso[sel];
        #HALF;
        sck = cpol;
      end else begin
        sck  = ~cpol;
        mosi = mosi_w[idx];
        #HALF;
        sck = cpol;
        miso_w[idx] = miso[sel];
        #HALF;
      end
    end
  endtask

  task automatic wait_rx(input int sel, input int target);
    int n;
    n = 0;
    while ((rxv_cnt[sel] < target) && (n < 40)) begin
      @(posedge clk);
      n++;
    end
    check("rx_valid_count", rxv_cnt[sel], target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"},   rx_data_v[0], 32'h0);
    check({tag, "_rx_valid"},  32'(rx_valid_v[0]), 32'd0);
    check({tag, "_tx_ready"},  32'(tx_ready_v[0]), 32'd1);
    check({tag, "_underrun"},  32'(und_v[0]), 32'd0);
    check({tag, "_busy"},      32'(busy[0]), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err[0]), 32'd0);
    check({tag, "_miso_oe"},   32'(miso_oe[0]), 32'd0);
    check({tag, "_miso"},      32'(miso[0]), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ferr_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      rxv_cnt[i]    = 0;
      und_cnt[i]    = 0;
      und_at_rxv[i] = 0;
      tx_data_v[i]  = '0;
      tx_valid_v[i] = 1'b0;
    end
    rst_n = 1'b0;
    sck   = 1'b0;
    mosi  = 1'b0;
    ss    = 4'hF;

    fork
      forever begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          if (und_v[i]) und_cnt[i]++;
          if (frame_err[i]) ferr_cnt++;
          if (rx_valid_v[i]) begin
            rxv_cnt[i]++;
            und_at_rxv[i] = und_cnt[i];
            check("rx_valid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
              mon_e = exp_q.pop_front();
              check("rx_instance", i, mon_e.inst);
              check("rx_data", rx_data_v[i], mon_e.data);
            end
          end
        end
      end
    join_none

    #32;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("post_reset");

    // Mode 0, buffered 0x3C, master sends 0xA5.
    buf_write(0, 32'h3C);
    exp_q.push_back('{inst: 0, data: 32'hA5});
    ss_low(0, 1'b0);
    check("m0_busy", 32'(busy[0]), 32'd1);
    check("m0_miso_oe", 32'(miso_oe[0]), 32'd1);
    check("m0_tx_ready_after_load", 32'(tx_ready_v[0]), 32'd1);
    spi_frame(0, 8, 1'b0, 1'b0, 1'b1, 32'hA5, 8, m1);
    ss_high(0);
    wait_rx(0, 1);
    check("m0_miso_word", m1, 32'h3C);
    check("m0_underrun_in_word", und_at_rxv[0], 0);
    check("m0_miso_oe_idle", 32'(miso_oe[0]), 32'd0);

    // Mode 3, LSB first, two back-to-back words from an empty buffer.
    exp_q.push_back('{inst: 3, data: 32'h01});
    exp_q.push_back('{inst: 3, data: 32'h80});
    ss_low(3, 1'b1);
    spi_frame(3, 8, 1'b1, 1'b1, 1'b0, 32'h01, 8, m1);
    spi_frame(3, 8, 1'b1, 1'b1, 1'b0, 32'h80, 8, m2);
    ss_high(3);
    wait_rx(3, 2);
    check("m3_miso_word1", m1, 32'hFF);
    check("m3_miso_word2", m2, 32'hFF);

    // Mode 1, empty buffer: idle pattern and one underrun within the word.
    exp_q.push_back('{inst: 1, data: 32'hC3});
    ss_low(1, 1'b0);
    spi_frame(1, 8, 1'b0, 1'b1, 1'b1, 32'hC3, 8, m1);
    ss_high(1);
    wait_rx(1, 1);
    check("m1_miso_word", m1, 32'hFF);
    check("m1_underrun_in_word", und_at_rxv[1], 1);
    check("m1_tx_ready", 32'(tx_ready_v[1]), 32'd1);

    // Mode 0, SS raised after 5 bits.
    ss_low(0, 1'b0);
    spi_frame(0, 8, 1'b0, 1'b0, 1'b1, 32'hFF, 5, m1);
    ss_high(0);
    repeat (20) @(posedge clk);
    check("partial_no_rx_valid", rxv_cnt[0], 1);
    check("partial_rx_data_held", rx_data_v[0], 32'hA5);
    check("partial_frame_err", ferr_cnt, FerrExp);

    // Reset after 3 bits with a word waiting in the buffer.
    buf_write(0, 32'h77);
    ss_low(0, 1'b0);
    buf_write(0, 32'h99);
    spi_frame(0, 8, 1'b0, 1'b0, 1'b1, 32'h00, 3, m1);
    rst_n = 1'b0;
    #20;
    check_reset_outputs("mid_word_reset");
    ss[0] = 1'b1;
    #50;
    rst_n = 1'b1;
    #100;
    exp_q.push_back('{inst: 0, data: 32'h5A});
    ss_low(0, 1'b0);
    spi_frame(0, 8, 1'b0, 1'b0, 1'b1, 32'h5A, 8, m1);
    ss_high(0);
    wait_rx(0, 2);
    check("after_reset_miso_word", m1, 32'hFF);

    // Mode 2, 16-bit word.
    buf_write(2, 32'h1234);
    exp_q.push_back('{inst: 2, data: 32'hBEEF});
    ss_low(2, 1'b1);
    check("m2_miso_oe_selected", 32'(miso_oe[2]), 32'd1);
    check("m2_miso_oe_other", 32'(miso_oe[0]), 32'd0);
    spi_frame(2, 16, 1'b1, 1'b0, 1'b1, 32'hBEEF, 16, m1);
    ss_high(2);
    wait_rx(2, 1);
    check("m2_miso_word", m1, 32'h1234);
    check("m2_miso_oe_idle", 32'(miso_oe[2]), 32'd0);

    repeat (10) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("frame_err_total", ferr_cnt, FerrExp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
